norm_align: RTL and testbench

NORM_ALIGN -- requirements
Module: norm_align

---
 rtl/div_pkg.sv | 12 +
 rtl/lzc.sv | 18 +
 rtl/norm_align.sv | 129 ++++++++++++
 tb/tb_norm_align.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider normalisation/alignment block.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero count; an all-zero input yields WIDTH.
module lzc #(
  parameter int WIDTH = 32,
  localparam int SW = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] a,
  output logic [SW-1:0]    count
);

  // Ascending scan: the highest set bit is the last to write count.
  always_comb begin
    count = SW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) count = SW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/norm_align.sv
// Divisor alignment: finds the largest k with (alb<<k) <= ala without losing bits,
// either one bit per cycle (FAST=0) or in a single cycle via leading-zero counts (FAST=1).
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | iterative search, one candidate shift per cycle (FAST=0 only)
// DONE  | results valid, one-cycle done pulse
module norm_align
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit FAST  = 1'b0,
  localparam int SW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             alrst,
  input  logic             start,
  input  logic [WIDTH-1:0] ala,
  input  logic [WIDTH-1:0] alb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shiftb,
  output logic [SW-1:0]    shamt,
  output logic             b_gt_a,
  output logic             div_zero
);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] cur;
  logic [SW-1:0]    cnt;

  logic [SW-1:0]    fast_k;
  logic [WIDTH-1:0] fast_shift;

  generate
    if (FAST) begin : g_fast
      logic [SW-1:0]    lz_a;
      logic [SW-1:0]    lz_b;
      logic [SW-1:0]    k0;
      logic [WIDTH-1:0] sh0;
      logic             over;

      lzc #(.WIDTH(WIDTH)) u_lzc_a (.a(ala), .count(lz_a));
      lzc #(.WIDTH(WIDTH)) u_lzc_b (.a(alb), .count(lz_b));

      // Aligning MSBs overshoots by at most one position.
      assign k0         = lz_b - lz_a;
      assign sh0        = alb << k0;
      assign over       = (sh0 > ala);
      assign fast_k     = over ? (k0 - 1'b1) : k0;
      assign fast_shift = over ? (sh0 >> 1) : sh0;
    end else begin : g_slow
      assign fast_k     = '0;
      assign fast_shift = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (alrst) begin
      state    <= IDLE;
      a_reg    <= '0;
      cur      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      shiftb   <= '0;
      shamt    <= '0;
      b_gt_a   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (alb == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
              b_gt_a   <= 1'b0;
              shamt    <= '0;
              shiftb   <= '0;
            end else if (alb > ala) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b0;
              b_gt_a   <= 1'b1;
              shamt    <= '0;
              shiftb   <= alb;
            end else if (FAST) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b0;
              b_gt_a   <= 1'b0;
              shamt    <= fast_k;
              shiftb   <= fast_shift;
            end else begin
              state <= SHIFT;
              a_reg <= ala;
              cur   <= alb;
              cnt   <= '0;
            end
          end
        end
        SHIFT: begin
          // Stop when the next shift would drop the MSB or exceed the dividend.
          if (cur[WIDTH-1] || ({cur[WIDTH-2:0], 1'b0} > a_reg)) begin
            state    <= DONE;
            done     <= 1'b1;
            div_zero <= 1'b0;
            b_gt_a   <= 1'b0;
            shamt    <= cnt;
            shiftb   <= cur;
          end else begin
            cur <= {cur[WIDTH-2:0], 1'b0};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_align.sv
// Directed and random checks of norm_align, iterative and fast variants side by side.
module tb_norm_align;

  localparam int WIDTH = 32;
  localparam int SW    = $clog2(WIDTH) + 1;
  localparam int RW    = SW + WIDTH + 2;

  logic             clk = 1'b0;
  logic             alrst;
  logic             start;
  logic [WIDTH-1:0] ala;
  logic [WIDTH-1:0] alb;

  logic             busy0, done0, bgt0, dz0;
  logic [WIDTH-1:0] shb0;
  logic [SW-1:0]    sa0;
  logic             busy1, done1, bgt1, dz1;
  logic [WIDTH-1:0] shb1;
  logic [SW-1:0]    sa1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  norm_align #(.WIDTH(WIDTH), .FAST(1'b0)) dut0 (
    .clk(clk), .alrst(alrst), .start(start), .ala(ala), .alb(alb),
    .busy(busy0), .done(done0), .shiftb(shb0), .shamt(sa0),
    .b_gt_a(bgt0), .div_zero(dz0)
  );

  norm_align #(.WIDTH(WIDTH), .FAST(1'b1)) dut1 (
    .clk(clk), .alrst(alrst), .start(start), .ala(ala), .alb(alb),
    .busy(busy1), .done(done1), .shiftb(shb1), .shamt(sa1),
    .b_gt_a(bgt1), .div_zero(dz1)
  );

  // Result packing: {shamt, shiftb, b_gt_a, div_zero}
  function automatic logic [RW-1:0] ref_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [63:0] bb;
    int k;
    if (b == '0) return {SW'(0), WIDTH'(0), 1'b0, 1'b1};
    if (b > a) return {SW'(0), b, 1'b1, 1'b0};
    bb = {32'h0, b};
    k = 0;
    while ((bb << 1) <= {32'h0, a}) begin
      bb = bb << 1;
      k++;
    end
    return {SW'(k), bb[WIDTH-1:0], 2'b00};
  endfunction

  function automatic int ref_lat0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [RW-1:0] r;
    if (b == '0 || b > a) return 1;
    r = ref_res(a, b);
    return int'(r[RW-1 -: SW]) + 2;
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int lat0, output int lat1,
                        output logic [RW-1:0] r0, output logic [RW-1:0] r1);
    lat0 = 0; lat1 = 0; r0 = '0; r1 = '0;
    @(negedge clk);
    ala = a; alb = b; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (done0 && lat0 == 0) begin lat0 = cyc; r0 = {sa0, shb0, bgt0, dz0}; end
      if (done1 && lat1 == 0) begin lat1 = cyc; r1 = {sa1, shb1, bgt1, dz1}; end
      if (lat0 != 0 && lat1 != 0) break;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    alrst = 1'b1; start = 1'b1; ala = 32'd100; alb = 32'd3;
    @(negedge clk);
    n_cmp++;
    if ({busy0, done0, sa0, shb0, bgt0, dz0} !== '0) begin
      n_err++;
      $display("FAIL reset_fast0 got=%h exp=0", {busy0, done0, sa0, shb0, bgt0, dz0});
    end
    n_cmp++;
    if ({busy1, done1, sa1, shb1, bgt1, dz1} !== '0) begin
      n_err++;
      $display("FAIL reset_fast1 got=%h exp=0", {busy1, done1, sa1, shb1, bgt1, dz1});
    end
    start = 1'b0; alrst = 1'b0;
  endtask

  task automatic test_basic();
    int l0, l1;
    logic [RW-1:0] r0, r1, exp;
    exp = {6'd5, 32'd96, 2'b00};
    run_op(32'd100, 32'd3, l0, l1, r0, r1);
    n_cmp++; if (r0 !== exp) begin n_err++; $display("FAIL basic_res0 got=%h exp=%h", r0, exp); end
    n_cmp++; if (r1 !== exp) begin n_err++; $display("FAIL basic_res1 got=%h exp=%h", r1, exp); end
    n_cmp++; if (l0 !== 7) begin n_err++; $display("FAIL basic_lat0 got=%0d exp=7", l0); end
    n_cmp++; if (l1 !== 1) begin n_err++; $display("FAIL basic_lat1 got=%0d exp=1", l1); end
    n_cmp++;
    if ({busy0, done0, busy1, done1} !== 4'b0) begin
      n_err++;
      $display("FAIL basic_idle_after got=%b exp=0000", {busy0, done0, busy1, done1});
    end
  endtask

  task automatic test_max_shift();
    int l0, l1;
    logic [RW-1:0] r0, r1, exp;
    exp = {6'd31, 32'h8000_0000, 2'b00};
    run_op(32'h8000_0000, 32'd1, l0, l1, r0, r1);
    n_cmp++; if (r0 !== exp) begin n_err++; $display("FAIL max_res0 got=%h exp=%h", r0, exp); end
    n_cmp++; if (r1 !== exp) begin n_err++; $display("FAIL max_res1 got=%h exp=%h", r1, exp); end
    n_cmp++; if (l0 !== 33) begin n_err++; $display("FAIL max_lat0 got=%0d exp=33", l0); end
    n_cmp++; if (l1 !== 1) begin n_err++; $display("FAIL max_lat1 got=%0d exp=1", l1); end
  endtask

  task automatic test_div_zero();
    int l0, l1;
    logic [RW-1:0] r0, r1, exp;
    exp = {6'd0, 32'd0, 2'b01};
    run_op(32'd5, 32'd0, l0, l1, r0, r1);
    n_cmp++; if (r0 !== exp) begin n_err++; $display("FAIL dz_res0 got=%h exp=%h", r0, exp); end
    n_cmp++; if (r1 !== exp) begin n_err++; $display("FAIL dz_res1 got=%h exp=%h", r1, exp); end
    n_cmp++; if (l0 !== 1) begin n_err++; $display("FAIL dz_lat0 got=%0d exp=1", l0); end
  endtask

  task automatic test_b_gt_a();
    int l0, l1;
    logic [RW-1:0] r0, r1, exp;
    exp = {6'd0, 32'd7, 2'b10};
    run_op(32'd5, 32'd7, l0, l1, r0, r1);
    n_cmp++; if (r0 !== exp) begin n_err++; $display("FAIL bgt_res0 got=%h exp=%h", r0, exp); end
    n_cmp++; if (r1 !== exp) begin n_err++; $display("FAIL bgt_res1 got=%h exp=%h", r1, exp); end
    n_cmp++; if (l0 !== 1) begin n_err++; $display("FAIL bgt_lat0 got=%0d exp=1", l0); end
  endtask

  task automatic test_equal();
    int l0, l1;
    logic [RW-1:0] r0, r1, exp;
    exp = {6'd0, 32'hFFFF_FFFF, 2'b00};
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, l0, l1, r0, r1);
    n_cmp++; if (r0 !== exp) begin n_err++; $display("FAIL eq_res0 got=%h exp=%h", r0, exp); end
    n_cmp++; if (r1 !== exp) begin n_err++; $display("FAIL eq_res1 got=%h exp=%h", r1, exp); end
    n_cmp++; if (l0 !== 2) begin n_err++; $display("FAIL eq_lat0 got=%0d exp=2", l0); end
  endtask

  // Start held while dut0 searches and while dut1 sits in DONE: both must ignore it.
  task automatic test_busy_ignore();
    int l0;
    logic [RW-1:0] r0, exp;
    exp = {6'd5, 32'd96, 2'b00};
    l0 = 0; r0 = '0;
    @(negedge clk);
    ala = 32'd100; alb = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL bi_done1 got=%b exp=1", done1); end
    ala = 32'd5; alb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({busy1, done1, sa1, shb1, bgt1, dz1} !== {2'b00, exp}) begin
      n_err++;
      $display("FAIL bi_dut1_hold got=%h exp=%h", {busy1, done1, sa1, shb1, bgt1, dz1}, {2'b00, exp});
    end
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL bi_busy0 got=%b exp=1", busy0); end
    for (int cyc = 3; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done0) begin l0 = cyc; r0 = {sa0, shb0, bgt0, dz0}; break; end
    end
    n_cmp++; if (l0 !== 7) begin n_err++; $display("FAIL bi_lat0 got=%0d exp=7", l0); end
    n_cmp++; if (r0 !== exp) begin n_err++; $display("FAIL bi_res0 got=%h exp=%h", r0, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int l0, l1;
    bit seen;
    logic [RW-1:0] r0, r1, exp;
    @(negedge clk);
    ala = 32'd100; alb = 32'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    alrst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy0, done0, sa0, shb0, bgt0, dz0} !== '0) begin
      n_err++;
      $display("FAIL abort_clear0 got=%h exp=0", {busy0, done0, sa0, shb0, bgt0, dz0});
    end
    n_cmp++;
    if ({busy1, done1, sa1, shb1, bgt1, dz1} !== '0) begin
      n_err++;
      $display("FAIL abort_clear1 got=%h exp=0", {busy1, done1, sa1, shb1, bgt1, dz1});
    end
    alrst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_done got=%b exp=0", seen); end
    exp = {6'd6, 32'd64, 2'b00};
    run_op(32'd100, 32'd1, l0, l1, r0, r1);
    n_cmp++; if (r0 !== exp) begin n_err++; $display("FAIL abort_rerun0 got=%h exp=%h", r0, exp); end
    n_cmp++; if (l0 !== 8) begin n_err++; $display("FAIL abort_lat0 got=%0d exp=8", l0); end
  endtask

  task automatic test_random();
    int l0, l1, el0;
    logic [WIDTH-1:0] a, b;
    logic [RW-1:0] r0, r1, exp;
    for (int i = 0; i < 24; i++) begin
      a = $urandom() >> $urandom_range(0, 8);
      b = $urandom() >> $urandom_range(0, 31);
      exp = ref_res(a, b);
      el0 = ref_lat0(a, b);
      run_op(a, b, l0, l1, r0, r1);
      n_cmp++;
      if (r0 !== exp) begin n_err++; $display("FAIL rnd_res0 a=%h b=%h got=%h exp=%h", a, b, r0, exp); end
      n_cmp++;
      if (r1 !== exp) begin n_err++; $display("FAIL rnd_res1 a=%h b=%h got=%h exp=%h", a, b, r1, exp); end
      n_cmp++;
      if (l0 !== el0) begin n_err++; $display("FAIL rnd_lat0 a=%h b=%h got=%0d exp=%0d", a, b, l0, el0); end
      n_cmp++;
      if (l1 !== 1) begin n_err++; $display("FAIL rnd_lat1 a=%h b=%h got=%0d exp=1", a, b, l1); end
    end
  endtask

  initial begin
    alrst = 1'b1; start = 1'b0; ala = '0; alb = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_max_shift();
    test_div_zero();
    test_b_gt_a();
    test_equal();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
